// File: rtl/note_lane_engine.sv
// note_lane_engine: LANES x SLOTS falling-note blocks with spawn, fall,
// key-hit judgement, miss detection and saturating event counters.
module note_lane_engine #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned H_W      = 10,
    parameter int unsigned SPAWN_H  = 120,
    parameter int unsigned BOTTOM_H = 720,
    parameter int unsigned HIT_LO   = 600,
    parameter int unsigned HIT_HI   = 680,
    parameter int unsigned STEP_W   = 3,
    localparam int unsigned LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        restart,
    input  logic                        stop_or_endgame,
    input  logic                        fall_tick,
    input  logic [STEP_W-1:0]           fall_step,
    input  logic                        spawn_valid,
    input  logic [LW-1:0]               spawn_lane,
    output logic                        spawn_ready,
    input  logic [LANES-1:0]            key_press,
    output logic [LANES*SLOTS*H_W-1:0]  block_h,
    output logic [LANES*SLOTS-1:0]      block_vld,
    output logic [LANES-1:0]            hit_pulse,
    output logic [LANES-1:0]            miss_pulse,
    output logic [15:0]                 hit_cnt,
    output logic [15:0]                 miss_cnt,
    output logic [15:0]                 drop_cnt
);
    localparam int unsigned NS = LANES * SLOTS;
    localparam int unsigned CW = $clog2(NS + 1);
    localparam logic [H_W:0]   BOT_X = (H_W + 1)'(BOTTOM_H);
    localparam logic [H_W-1:0] BOT_H = H_W'(BOTTOM_H);
    localparam logic [H_W-1:0] SPN_H = H_W'(SPAWN_H);
    localparam logic [H_W-1:0] HLO   = H_W'(HIT_LO);
    localparam logic [H_W-1:0] HHI   = H_W'(HIT_HI);

    logic [NS-1:0]    vld_q, vld_d;
    logic [H_W-1:0]   h_q [NS];
    logic [H_W-1:0]   h_d [NS];
    logic [LANES-1:0] hitp_q, hitp_d, missp_q, missp_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, drop_cnt_q, drop_cnt_d;

    logic             lane_ok;
    logic             sel_free;
    logic [NS-1:0]    hit_sel;
    logic             found;
    logic [H_W-1:0]   best_h;
    int unsigned      best_i;
    logic [H_W:0]     sum;
    logic [CW-1:0]    nhit, nmiss;
    logic             placed;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Spawn acceptance: valid lane with at least one free slot in the pre-cycle state
    always_comb begin
        lane_ok  = 32'(spawn_lane) < LANES;
        sel_free = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (spawn_lane == LW'(l)) sel_free = ~&vld_q[l*SLOTS +: SLOTS];
        end
        spawn_ready = !stop_or_endgame && lane_ok && sel_free;
    end

    // Hit candidate per lane: highest in-window block, lowest index on ties
    always_comb begin
        hit_sel = '0;
        found   = 1'b0;
        best_h  = '0;
        best_i  = 0;
        for (int unsigned l = 0; l < LANES; l++) begin
            found  = 1'b0;
            best_h = '0;
            best_i = 0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (key_press[l] && vld_q[l*SLOTS+s] && h_q[l*SLOTS+s] >= HLO &&
                    h_q[l*SLOTS+s] <= HHI && (!found || h_q[l*SLOTS+s] > best_h)) begin
                    found  = 1'b1;
                    best_h = h_q[l*SLOTS+s];
                    best_i = l*SLOTS + s;
                end
            end
            if (found && !stop_or_endgame) hit_sel[best_i] = 1'b1;
        end
    end

    // Next state: restart clears, stop holds, else hit > miss/move, then spawn
    always_comb begin
        vld_d      = vld_q;
        h_d        = h_q;
        hitp_d     = '0;
        missp_d    = '0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        drop_cnt_d = drop_cnt_q;
        sum        = '0;
        nhit       = '0;
        nmiss      = '0;
        placed     = 1'b0;
        if (restart) begin
            vld_d      = '0;
            for (int unsigned i = 0; i < NS; i++) h_d[i] = BOT_H;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            drop_cnt_d = '0;
        end else if (!stop_or_endgame) begin
            for (int unsigned i = 0; i < NS; i++) begin
                sum = {1'b0, h_q[i]} + (H_W + 1)'(fall_step);
                if (hit_sel[i]) begin
                    vld_d[i]            = 1'b0;
                    h_d[i]              = BOT_H;
                    hitp_d[i / SLOTS]   = 1'b1;
                    nhit                = nhit + CW'(1);
                end else if (vld_q[i] && fall_tick) begin
                    if (sum >= BOT_X) begin
                        vld_d[i]           = 1'b0;
                        h_d[i]             = BOT_H;
                        missp_d[i / SLOTS] = 1'b1;
                        nmiss              = nmiss + CW'(1);
                    end else begin
                        h_d[i] = sum[H_W-1:0];
                    end
                end
            end
            // Spawn targets a slot free before this cycle, so it never collides with hit/move
            if (spawn_valid) begin
                if (lane_ok && sel_free) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        for (int unsigned s = 0; s < SLOTS; s++) begin
                            if (spawn_lane == LW'(l) && !placed && !vld_q[l*SLOTS+s]) begin
                                placed            = 1'b1;
                                vld_d[l*SLOTS+s]  = 1'b1;
                                h_d[l*SLOTS+s]    = SPN_H;
                            end
                        end
                    end
                end else begin
                    drop_cnt_d = sat_add(drop_cnt_q, CW'(1));
                end
            end
            hit_cnt_d  = sat_add(hit_cnt_q, nhit);
            miss_cnt_d = sat_add(miss_cnt_q, nmiss);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            for (int unsigned i = 0; i < NS; i++) h_q[i] <= BOT_H;
            hitp_q     <= '0;
            missp_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            h_q        <= h_d;
            hitp_q     <= hitp_d;
            missp_q    <= missp_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Flatten slot state onto the output buses
    always_comb begin
        block_h = '0;
        for (int unsigned i = 0; i < NS; i++) block_h[i*H_W +: H_W] = h_q[i];
        block_vld  = vld_q;
        hit_pulse  = hitp_q;
        miss_pulse = missp_q;
        hit_cnt    = hit_cnt_q;
        miss_cnt   = miss_cnt_q;
        drop_cnt   = drop_cnt_q;
    end
endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboard bench for note_lane_engine: a lane/slot reference model predicts
// each registered output; a monitor compares one cycle after every drive.
module tb_note_lane_engine;
    localparam int LANES = 3;
    localparam int SLOTS = 4;
    localparam int H_W = 10;
    localparam int SPAWN_H = 120;
    localparam int BOTTOM_H = 720;
    localparam int HIT_LO = 600;
    localparam int HIT_HI = 716;
    localparam int STEP_W = 3;
    localparam int LW = 2;
    localparam int NS = LANES * SLOTS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0, stop_or_endgame = 1'b0, fall_tick = 1'b0, spawn_valid = 1'b0;
    logic [STEP_W-1:0] fall_step = '0;
    logic [LW-1:0] spawn_lane = '0;
    logic spawn_ready;
    logic [LANES-1:0] key_press = '0;
    logic [NS*H_W-1:0] block_h;
    logic [NS-1:0] block_vld;
    logic [LANES-1:0] hit_pulse, miss_pulse;
    logic [15:0] hit_cnt, miss_cnt, drop_cnt;

    note_lane_engine #(
        .LANES(LANES), .SLOTS(SLOTS), .H_W(H_W), .SPAWN_H(SPAWN_H), .BOTTOM_H(BOTTOM_H),
        .HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .stop_or_endgame(stop_or_endgame),
        .fall_tick(fall_tick), .fall_step(fall_step), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .key_press(key_press),
        .block_h(block_h), .block_vld(block_vld), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS*H_W-1:0] h;
        logic [NS-1:0]     v;
        logic [LANES-1:0]  hp;
        logic [LANES-1:0]  mp;
        logic [15:0]       hc;
        logic [15:0]       mc;
        logic [15:0]       dc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: per lane a list of block heights (-1 = empty slot)
    int m_h[LANES][SLOTS];
    int m_hc, m_mc, m_dc;
    bit m_hp[LANES], m_mp[LANES];

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) m_h[l][s] = -1;
            m_hp[l] = 0;
            m_mp[l] = 0;
        end
        m_hc = 0; m_mc = 0; m_dc = 0;
    endtask

    function automatic bit lane_has_room(input int lane);
        if (lane >= LANES) return 0;
        foreach (m_h[lane][s]) if (m_h[lane][s] < 0) return 1;
        return 0;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                int i;
                i = l * SLOTS + s;
                e.v[i] = (m_h[l][s] >= 0);
                e.h[i*H_W +: H_W] = H_W'((m_h[l][s] >= 0) ? m_h[l][s] : BOTTOM_H);
            end
            e.hp[l] = m_hp[l];
            e.mp[l] = m_mp[l];
        end
        e.hc = 16'(m_hc); e.mc = 16'(m_mc); e.dc = 16'(m_dc);
        return e;
    endfunction

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic model_cycle(input bit rs, input bit st, input bit tk, input int step,
                               input bit sv, input int lane, input logic [LANES-1:0] keys);
        int nh[LANES][SLOTS];
        if (rs) begin
            model_reset();
            return;
        end
        for (int l = 0; l < LANES; l++) begin m_hp[l] = 0; m_mp[l] = 0; end
        if (st) return;
        nh = m_h;
        for (int l = 0; l < LANES; l++) begin
            int top, pick;
            top = -1; pick = -1;
            if (keys[l]) begin
                foreach (m_h[l][s])
                    if (m_h[l][s] >= HIT_LO && m_h[l][s] <= HIT_HI && m_h[l][s] > top) top = m_h[l][s];
                foreach (m_h[l][s]) if (pick < 0 && top >= 0 && m_h[l][s] == top) pick = s;
            end
            for (int s = 0; s < SLOTS; s++) begin
                if (s == pick) begin
                    nh[l][s] = -1;
                    m_hp[l] = 1;
                    m_hc = sat(m_hc + 1);
                end else if (m_h[l][s] >= 0 && tk) begin
                    if (m_h[l][s] + step >= BOTTOM_H) begin
                        nh[l][s] = -1;
                        m_mp[l] = 1;
                        m_mc = sat(m_mc + 1);
                    end else begin
                        nh[l][s] = m_h[l][s] + step;
                    end
                end
            end
        end
        if (sv) begin
            if (lane_has_room(lane)) begin
                int first;
                first = -1;
                foreach (m_h[lane][s]) if (first < 0 && m_h[lane][s] < 0) first = s;
                nh[lane][first] = SPAWN_H;
            end else begin
                m_dc = sat(m_dc + 1);
            end
        end
        m_h = nh;
    endtask

    task automatic cmp(input string name, input logic [NS*H_W-1:0] got, input logic [NS*H_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        cmp("block_h", block_h, e.h);
        cmp("block_vld", (NS*H_W)'(block_vld), (NS*H_W)'(e.v));
        cmp("hit_pulse", (NS*H_W)'(hit_pulse), (NS*H_W)'(e.hp));
        cmp("miss_pulse", (NS*H_W)'(miss_pulse), (NS*H_W)'(e.mp));
        cmp("hit_cnt", (NS*H_W)'(hit_cnt), (NS*H_W)'(e.hc));
        cmp("miss_cnt", (NS*H_W)'(miss_cnt), (NS*H_W)'(e.mc));
        cmp("drop_cnt", (NS*H_W)'(drop_cnt), (NS*H_W)'(e.dc));
    endtask

    // One cycle of stimulus: drive at negedge, check spawn_ready, predict, enqueue
    task automatic drive(input bit rs, input bit st, input bit tk, input int step,
                         input bit sv, input int lane, input logic [LANES-1:0] keys);
        bit want_ready;
        @(negedge clk);
        restart = rs; stop_or_endgame = st; fall_tick = tk; fall_step = STEP_W'(step);
        spawn_valid = sv; spawn_lane = LW'(lane); key_press = keys;
        #1;
        want_ready = !st && lane_has_room(lane);
        cmp("spawn_ready", (NS*H_W)'(spawn_ready), (NS*H_W)'(want_ready));
        model_cycle(rs, st, tk, step, sv, lane, keys);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle(); drive(0, 0, 0, 0, 0, 0, '0); endtask
    task automatic rst_game(); drive(1, 0, 0, 0, 0, 0, '0); endtask
    task automatic spawn(input int lane); drive(0, 0, 0, 0, 1, lane, '0); endtask
    task automatic ticks(input int n, input int step);
        repeat (n) drive(0, 0, 1, step, 0, 0, '0);
    endtask
    task automatic key(input logic [LANES-1:0] k); drive(0, 0, 0, 0, 0, 0, k); endtask

    function automatic logic [LANES-1:0] rand_keys(input int pct);
        logic [LANES-1:0] k;
        for (int l = 0; l < LANES; l++) k[l] = ($urandom_range(99) < pct);
        return k;
    endfunction

    // Monitor: every output update is compared against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_out(e);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check_out(snapshot());
        @(negedge clk);
        rst_n = 1'b1;

        // single block falls to the bottom at step 4
        spawn(0);
        ticks(151, 4);

        // fill lane 2, overflow, and a spawn to a non-existent lane
        repeat (5) spawn(2);
        spawn(3);
        spawn(1);

        // two blocks in lane 1 at 650 and 610; highest one hit first
        rst_game();
        spawn(1);
        ticks(10, 4);
        spawn(1);
        ticks(98, 5);
        key(3'b010);
        key(3'b010);
        key(3'b010);

        // lower boundary: 599 ignored, 600 hit
        rst_game();
        spawn(0);
        ticks(68, 7);
        ticks(1, 3);
        key(3'b001);
        ticks(1, 1);
        key(3'b001);

        // upper boundary: 717 ignored; 716 hit while the same tick would miss it
        rst_game();
        spawn(2);
        ticks(85, 7);
        ticks(1, 2);
        key(3'b100);
        rst_game();
        spawn(2);
        ticks(85, 7);
        ticks(1, 1);
        drive(0, 0, 1, 4, 0, 0, 3'b100);
        idle();

        // freeze with activity on every input, then resume
        rst_game();
        for (int l = 0; l < LANES; l++) spawn(l);
        ticks(70, 7);
        repeat (10) drive(0, 1, 1, $urandom_range(7), 1, $urandom_range(3), rand_keys(50));
        ticks(5, 6);

        // randomized play
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(999) < 3, $urandom_range(99) < 5, $urandom_range(1),
                  $urandom_range(7), $urandom_range(99) < 35, $urandom_range(3), rand_keys(15));
        end

        // restart with six active blocks and nonzero counters
        for (int l = 0; l < LANES; l++) begin spawn(l); spawn(l); end
        ticks(3, 5);
        rst_game();
        idle();

        // asynchronous reset mid-cycle
        for (int l = 0; l < LANES; l++) spawn(l);
        spawn(3);
        ticks(4, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out(snapshot());
        rst_n = 1'b1;
        spawn(1);
        ticks(3, 2);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_lane_engine.md
# note_lane_engine

Multi-lane falling-note engine for the piano game. It generalises the single hard-coded falling block into LANES lanes of SLOTS independent blocks each, with externally driven spawns, programmable fall step, key-hit judgement and miss detection. It sits between the beat/chart logic (spawn requests) and the VGA renderer (block heights) and scoring (hit/miss pulses and counters).

## Interface
Parameters:
- LANES, 4, number of key lanes (1..8)
- SLOTS, 4, concurrent blocks per lane (1..8)
- H_W, 10, height/pixel coordinate width
- SPAWN_H, 120, height loaded into a newly spawned block
- BOTTOM_H, 720, height at or beyond which a block is missed and freed; idle slots read this value
- HIT_LO, 600, lower bound of hit window (inclusive)
- HIT_HI, 680, upper bound of hit window (inclusive)
- STEP_W, 3, width of fall_step

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous clear of all slots and counters
- stop_or_endgame  in  1  freeze: no motion, no spawns, keys ignored
- fall_tick  in  1  one-cycle motion enable (frame/beat-tenth strobe)
- fall_step  in  STEP_W  pixels added per fall_tick
- spawn_valid  in  1  spawn request, single cycle
- spawn_lane  in  clog2(LANES) (min 1)  target lane of spawn
- spawn_ready  out  1  combinational: target lane has a free slot and not stopped
- key_press  in  LANES  one-cycle key pulses, one bit per lane
- block_h  out  LANES*SLOTS*H_W  slot heights, slot s of lane l at index (l*SLOTS+s)*H_W
- block_vld  out  LANES*SLOTS  slot active flags, same ordering
- hit_pulse  out  LANES  one-cycle pulse per lane on successful hit
- miss_pulse  out  LANES  one-cycle pulse per lane when ≥1 block falls out
- hit_cnt  out  16  total hits, saturating
- miss_cnt  out  16  total missed blocks, saturating
- drop_cnt  out  16  spawn requests lost to a full lane, saturating

## Operation
- Per slot state: vld bit and H_W-bit height. Idle slot: vld=0, h=BOTTOM_H.
- Each cycle, evaluated from the registered (pre-cycle) state, in priority order per slot: hit, miss, move, spawn.
- Hit: key_press[l] and not stopped selects, among active slots of lane l with HIT_LO ≤ h ≤ HIT_HI, the one with greatest h (ties → lowest index). That slot is freed; hit_pulse[l]=1; hit_cnt+1. No candidate → key ignored, no penalty. At most one hit per lane per cycle.
- Move: fall_tick and not stopped: every active, non-hit slot computes h+fall_step in H_W+1 bits. Sum ≥ BOTTOM_H → slot freed, miss. Else h ← sum. fall_step=0 → no motion, no misses.
- Miss: miss_cnt increments by the number of slots missed that cycle (all lanes), saturating at 16'hFFFF; miss_pulse[l]=1 if any slot of lane l missed.
- Spawn: spawn_valid and not stopped: lowest-index slot free in the pre-cycle state of spawn_lane gets vld=1, h=SPAWN_H. Slots freed this cycle are not reusable until the next cycle. Lane full → request dropped, drop_cnt+1. spawn_lane ≥ LANES → dropped, drop_cnt+1.
- spawn_ready = !stop_or_endgame && spawn_lane < LANES && any pre-cycle free slot in spawn_lane.
- stop_or_endgame: all state held, pulses 0, counters held.
- restart (not stopped-qualified): next edge all slots idle, all counters 0, pulses 0; overrides all other events that cycle.

## Timing
- Reset (rst_n=0, asynchronous): block_vld=0, every block_h=BOTTOM_H, hit_pulse=0, miss_pulse=0, hit_cnt=miss_cnt=drop_cnt=0.
- All outputs except spawn_ready are registered; hit/miss/spawn/move effects visible one cycle after the input cycle.
- Spawn in cycle N → block_vld=1, h=SPAWN_H after edge N; first motion on the next fall_tick (N+1 or later).
- Hit and miss for same slot same cycle: hit wins, only hit counted.
- Key press and spawn in same lane same cycle: both take effect.
- Counter saturation: holds at 16'hFFFF, never wraps.

## Test plan
- Reset then single spawn lane 0, fall_step=4, fall_tick every cycle → slot0 h=120,124,…; at h=716 next tick frees slot, miss_pulse[0]=1, miss_cnt=1.
- Fill lane 2 with 4 spawns, fifth spawn → spawn_ready=0 before edge, drop_cnt=1, other lanes unaffected.
- Two blocks lane 1 at h=610 and h=650, key_press[1] → slot at 650 freed, hit_pulse[1]=1, hit_cnt=1; 610 block remains.
- key_press with block at h=599 and h=681 → no hit, state unchanged; block at 716, step 4, key pressed same cycle with HIT_HI raised to 720 → hit counted, no miss.
- stop_or_endgame=1 for 10 cycles with ticks, spawns, keys → heights, vld, counters unchanged; release resumes motion from held heights.
- restart mid-play with 6 active blocks and nonzero counters → next cycle all idle, h=720, counters 0; rst_n low asynchronously mid-cycle → outputs reset immediately.
